sram_mmio_responder: RTL and testbench
======================================

Name: sram_mmio_responder

Overview:
- Responder side of the CPU data-SRAM interface: a memory-mapped peripheral register block the data SRAM port addresses directly.
- Decodes a 64 KiB window and serves reads with fixed 1-cycle latency: timer, LED, switch, scratch and UART TX registers.
- Sits beside the data RAM at SoC top; the top muxes rdata on the registered hit flag.
- Contains a byte TX FIFO draining to a valid/ready UART port.

Parameters:
- BASE_ADDR, 32'hBFAF_0000, window base; only bits [31:16] are compared.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
- SW_W, 8, switch input width.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- data_sram_en  in  1  request strobe
- data_sram_we  in  4  byte write enables; 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, valid the cycle after en
- mmio_hit  out  1  registered: the previous-cycle request hit the window
- led  out  16  LED register
- switch  in  SW_W  asynchronous switch inputs
- uart_tx_valid  out  1  FIFO head valid
- uart_tx_data  out  8  FIFO head byte
- uart_tx_ready  in  1  sink accepts head

Behaviour:
- Clocking and reset: resetn is synchronous and active-low, sampled on the clk rising edge.
- Reset values: rdata=0, mmio_hit=0, led=0, TIMER=0, NUM=0, FIFO empty, uart_tx_valid=0, overflow=0, switch synchronizers=0.
- Hit decode: hit = en & (addr[31:16]==BASE_ADDR[31:16]). Offset = addr[15:0]; addr[1:0] are ignored.
- Register map:
  - 0x00 TIMER: RW. Free-running, +1 per cycle, wraps at 2^32.
  - 0x04 LED: RW. Bits [15:0]; we[1:0] only; upper bits read 0.
  - 0x08 SWITCH: RO. Two-flop synchronized switch, zero-extended.
  - 0x0C NUM: RW 32-bit scratch.
  - 0x10 UART_DATA: WO. A write with we[0]=1 enqueues wdata[7:0]; reads return 0.
  - 0x14 UART_STAT: [0] empty, [1] full, [2] overflow sticky (W1C via we[0]), [15:8] count; other bits 0.
  - Any other offset: reads 0, writes ignored.
- Writes: each of the 4 bytes is updated only where we[i]=1, in the request cycle's edge.
- Timer write conflict: the write wins. The written bytes are loaded; unwritten bytes keep their pre-increment value. Incrementing resumes the next cycle.
- Reads (we==0, hit):
  - rdata is registered and returns the register value as sampled in the request cycle.
  - A TIMER read at cycle t returns the value before the t edge.
- Requests with we!=0 return rdata=0 next cycle.
- en low, or no hit: rdata is driven to 0 next cycle and mmio_hit=0.
- Back-to-back requests every cycle are supported; there is no stall and no ready signal.
- Enqueue to the FIFO:
  - Accepted only if count<FIFO_DEPTH, evaluated before this cycle's pop.
  - When full, the byte is dropped and overflow is set to 1.
  - Overflow set and W1C in the same cycle: set wins.
- Dequeue: uart_tx_valid = !empty. Pop occurs on valid & uart_tx_ready. uart_tx_data is the head entry, stable while valid & !ready.
- Simultaneous push and pop, not full: count unchanged, both pointers advance.
- Empty plus push: valid rises the next cycle; no bypass.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. full/empty come from pointer MSB comparison.
- Reset asserted mid-operation clears FIFO contents, pointers and all registers at the next edge. Any in-flight rdata is lost (rdata=0).

Decomposition:
- Shared package mmio_pkg holds:
  - offset constants OFF_TIMER/OFF_LED/OFF_SWITCH/OFF_NUM/OFF_UART_DATA/OFF_UART_STAT;
  - STAT bit-position constants;
  - a byte-mask merge function.
- One sub-module tx_byte_fifo (parameter DEPTH). It takes push/din and pop/dout and provides empty/full/count. Its reset is synchronous and active-low on resetn.

Test Plan:
- Reset, then read 0x04, 0x0C, 0x14 → rdata 0, 0, 0x0000_0001 (empty=1).
- Write 0x0C wdata=0xDEADBEEF with we=4'b0101, then read → 0x00AD00EF. Then write LED with we=4'b1111 and 0xFFFF_1234 → led=16'h1234, read 0x04 → 0x00001234.
- Write TIMER=0x0000_0010 at cycle t, then read at t+3 → 0x00000012; separately write TIMER=0xFFFFFFFF, read 2 cycles later → 0x00000000 (wrap).
- Hold uart_tx_ready=0 and write 9 bytes 0x41..0x49 → STAT=0x0000_0806 (count 8, full, overflow). Release ready → bytes 0x41..0x48 emerge in order, one per cycle, then valid=0. W1C bit 2 → STAT=0x01.
- Push and pop in the same cycle at count=3 → count stays 3 and order is preserved. Assert resetn=0 for 1 cycle mid-drain → valid=0 and count=0 the next cycle.
- Set switch=0xA5 → read 0x08 at least 3 cycles later returns 0xA5. A read to addr 0xBFAE_0008 (miss) → rdata 0 and mmio_hit 0. A read to unmapped offset 0x20 → rdata 0 and mmio_hit 1.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the SRAM-port MMIO responder: register offsets,
// UART status bit positions and the byte-enable merge helper.
package mmio_pkg;

    // Word offsets inside the 64 KiB window (addr[1:0] are dropped before compare)
    localparam logic [15:0] OFF_TIMER     = 16'h0000;
    localparam logic [15:0] OFF_LED       = 16'h0004;
    localparam logic [15:0] OFF_SWITCH    = 16'h0008;
    localparam logic [15:0] OFF_NUM       = 16'h000C;
    localparam logic [15:0] OFF_UART_DATA = 16'h0010;
    localparam logic [15:0] OFF_UART_STAT = 16'h0014;

    // UART_STAT field positions
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_CNT_LSB   = 8;
    localparam int unsigned STAT_CNT_W     = 8;

    // Replace the bytes of old_v selected by be with the matching bytes of new_v
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO feeding the UART TX port.
// Ports: clk/resetn (sync, active-low), push_i/din_i write side,
//        pop_i/dout_o read side (dout_o is the head entry),
//        empty_o/full_o/count_o status.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tx_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic [7:0]                 din_i,
    input  logic                       pop_i,
    output logic [7:0]                 dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push_c;
    logic        do_pop_c;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push_c = push_i & ~full_o;
    assign do_pop_c  = pop_i & ~empty_o;

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push_c) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
            end
        end
    end

endmodule

// File: rtl/sram_mmio_responder.sv
// MMIO register block on the CPU data-SRAM port.
// Ports: clk/resetn (sync, active-low); data_sram_en/we/addr/wdata request;
//        data_sram_rdata + mmio_hit registered response (1-cycle latency);
//        led register output; switch async input; uart_tx_valid/data/ready
//        valid/ready byte stream drained from the internal TX FIFO.
module sram_mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hBFAF_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SW_W       = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            data_sram_en,
    input  logic [3:0]      data_sram_we,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic [31:0]     data_sram_rdata,
    output logic            mmio_hit,
    output logic [15:0]     led,
    input  logic [SW_W-1:0] switch,
    output logic            uart_tx_valid,
    output logic [7:0]      uart_tx_data,
    input  logic            uart_tx_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]     timer_q, timer_d;
    logic [31:0]     num_q, num_d;
    logic [15:0]     led_q, led_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            hit_q;
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;

    logic            hit_c, wr_c, rd_c;
    logic [15:0]     off_c;
    logic [31:0]     led_wr_c;
    logic [31:0]     stat_c;
    logic            push_req_c;
    logic            fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]      fifo_dout;
    logic            unused_addr_lsb;

    assign hit_c           = data_sram_en && (data_sram_addr[31:16] == BASE_ADDR[31:16]);
    assign off_c           = {data_sram_addr[15:2], 2'b00};
    assign wr_c            = hit_c && (data_sram_we != 4'b0000);
    assign rd_c            = hit_c && (data_sram_we == 4'b0000);
    assign push_req_c      = wr_c && (off_c == OFF_UART_DATA) && data_sram_we[0];
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push_req_c & ~fifo_full),
        .din_i   (data_sram_wdata[7:0]),
        .pop_i   (uart_tx_valid & uart_tx_ready),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign uart_tx_valid   = ~fifo_empty;
    assign uart_tx_data    = fifo_dout;
    assign data_sram_rdata = rdata_q;
    assign mmio_hit        = hit_q;
    assign led             = led_q;

    // Register writes, overflow flag and read-data selection
    always_comb begin
        timer_d  = timer_q + 32'd1;
        num_d    = num_q;
        led_d    = led_q;
        ovf_d    = ovf_q;
        rdata_d  = '0;
        led_wr_c = merge_bytes({16'h0000, led_q}, data_sram_wdata, {2'b00, data_sram_we[1:0]});

        stat_c                                 = '0;
        stat_c[STAT_EMPTY_BIT]                 = fifo_empty;
        stat_c[STAT_FULL_BIT]                  = fifo_full;
        stat_c[STAT_OVF_BIT]                   = ovf_q;
        stat_c[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);

        if (wr_c) begin
            unique case (off_c)
                // Written bytes come from wdata; the others hold the pre-increment value
                OFF_TIMER:     timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_we);
                OFF_LED:       led_d   = led_wr_c[15:0];
                OFF_NUM:       num_d   = merge_bytes(num_q, data_sram_wdata, data_sram_we);
                OFF_UART_STAT: if (data_sram_we[0] && data_sram_wdata[STAT_OVF_BIT]) ovf_d = 1'b0;
                default:       ;
            endcase
        end
        // Dropped enqueue sets overflow after any clear, so set wins
        if (push_req_c && fifo_full) ovf_d = 1'b1;

        if (rd_c) begin
            unique case (off_c)
                OFF_TIMER:     rdata_d = timer_q;
                OFF_LED:       rdata_d = {16'h0000, led_q};
                OFF_SWITCH:    rdata_d = 32'(sw_sync_q);
                OFF_NUM:       rdata_d = num_q;
                OFF_UART_STAT: rdata_d = stat_c;
                default:       rdata_d = '0;
            endcase
        end
    end

    // State registers, response registers and switch synchronizer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer_q   <= '0;
            num_q     <= '0;
            led_q     <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
            hit_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            timer_q   <= timer_d;
            num_q     <= num_d;
            led_q     <= led_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            hit_q     <= hit_c;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

endmodule

// File: tb/tb_sram_mmio_responder.sv
// Self-checking bench for sram_mmio_responder: every issued request pushes
// its expected response into a queue that is popped one cycle later.
module tb_sram_mmio_responder;

    localparam logic [31:0] BASE = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        mmio_hit;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;

    int n_chk = 0;
    int n_err = 0;

    // {check, hit, rdata}
    logic [33:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    sram_mmio_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .SW_W       (8)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .mmio_hit        (mmio_hit),
        .led             (led),
        .switch          (switch),
        .uart_tx_valid   (uart_tx_valid),
        .uart_tx_data    (uart_tx_data),
        .uart_tx_ready   (uart_tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock and compare the response owed for the previous request
    task automatic tick();
        logic [33:0] e;
        string       t;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e[33]) begin
                chk({t, ".rdata"}, data_sram_rdata, e[31:0]);
                chk({t, ".hit"}, {31'b0, mmio_hit}, {31'b0, e[32]});
            end
        end
    endtask

    task automatic issue(input string tag, input logic en, input logic [31:0] addr,
                         input logic [3:0] we, input logic [31:0] wd,
                         input logic do_chk, input logic [31:0] exp_rd, input logic exp_hit);
        data_sram_en    = en;
        data_sram_addr  = addr;
        data_sram_we    = we;
        data_sram_wdata = wd;
        exp_q.push_back({do_chk, exp_hit, exp_rd});
        tag_q.push_back(tag);
        tick();
        data_sram_en = 1'b0;
        data_sram_we = 4'b0000;
    endtask

    task automatic idle();
        issue("idle", 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [15:0] off, input logic [3:0] we, input logic [31:0] wd);
        issue(tag, 1'b1, BASE | 32'(off), we, wd, 1'b1, 32'h0, 1'b1);
    endtask

    task automatic rd(input string tag, input logic [15:0] off, input logic [31:0] exp);
        issue(tag, 1'b1, BASE | 32'(off), 4'b0000, 32'h0, 1'b1, exp, 1'b1);
    endtask

    initial begin
        resetn          = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'b0000;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        switch          = 8'h00;
        uart_tx_ready   = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst.rdata", data_sram_rdata, 32'h0);
        chk("rst.hit",   {31'b0, mmio_hit}, 32'h0);
        chk("rst.led",   {16'h0, led}, 32'h0);
        chk("rst.valid", {31'b0, uart_tx_valid}, 32'h0);
        resetn = 1'b1;

        rd("rd_led0",  16'h0004, 32'h0);
        rd("rd_num0",  16'h000C, 32'h0);
        rd("rd_stat0", 16'h0014, 32'h0000_0001);

        // Byte-enable writes
        wr("wr_num", 16'h000C, 4'b0101, 32'hDEAD_BEEF);
        rd("rd_num", 16'h000C, 32'h00AD_00EF);
        wr("wr_led", 16'h0004, 4'b1111, 32'hFFFF_1234);
        chk("led_out", {16'h0, led}, 32'h0000_1234);
        rd("rd_led", 16'h0004, 32'h0000_1234);
        rd("rd_led_lsb", 16'h0006, 32'h0000_1234);

        // Timer load and wrap
        wr("wr_tmr", 16'h0000, 4'b1111, 32'h0000_0010);
        idle();
        idle();
        rd("rd_tmr", 16'h0000, 32'h0000_0012);
        wr("wr_tmr_ff", 16'h0000, 4'b1111, 32'hFFFF_FFFF);
        idle();
        rd("rd_tmr_wrap", 16'h0000, 32'h0000_0000);

        // Fill past capacity with the sink stalled
        for (int i = 0; i < 9; i++) begin
            wr("push", 16'h0010, 4'b0001, 32'h0000_0041 + 32'(i));
        end
        rd("rd_stat_full", 16'h0014, 32'h0000_0806);
        rd("rd_uart_data", 16'h0010, 32'h0);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain.valid", {31'b0, uart_tx_valid}, 32'h1);
            chk("drain.data", {24'h0, uart_tx_data}, 32'h41 + 32'(i));
            idle();
        end
        chk("drained.valid", {31'b0, uart_tx_valid}, 32'h0);
        wr("w1c_ovf", 16'h0014, 4'b0001, 32'h0000_0004);
        rd("rd_stat_clr", 16'h0014, 32'h0000_0001);

        // Simultaneous push and pop at count 3
        uart_tx_ready = 1'b0;
        wr("push_a", 16'h0010, 4'b0001, 32'h50);
        wr("push_b", 16'h0010, 4'b0001, 32'h51);
        wr("push_c", 16'h0010, 4'b0001, 32'h52);
        uart_tx_ready = 1'b1;
        chk("pp.head", {24'h0, uart_tx_data}, 32'h50);
        wr("push_pop", 16'h0010, 4'b0001, 32'h53);
        uart_tx_ready = 1'b0;
        rd("rd_stat_pp", 16'h0014, 32'h0000_0300);
        chk("pp.head2", {24'h0, uart_tx_data}, 32'h51);
        uart_tx_ready = 1'b1;
        idle();
        chk("pp.head3", {24'h0, uart_tx_data}, 32'h52);
        idle();
        chk("pp.head4", {24'h0, uart_tx_data}, 32'h53);
        chk("pp.valid4", {31'b0, uart_tx_valid}, 32'h1);

        // Reset mid-drain
        resetn = 1'b0;
        issue("rst_mid", 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        resetn = 1'b1;
        chk("rst_mid.valid", {31'b0, uart_tx_valid}, 32'h0);
        chk("rst_mid.led", {16'h0, led}, 32'h0);
        rd("rd_stat_rst", 16'h0014, 32'h0000_0001);
        rd("rd_num_rst", 16'h000C, 32'h0);

        // Switch synchronizer, window miss, unmapped offset
        switch = 8'hA5;
        idle();
        idle();
        idle();
        rd("rd_sw", 16'h0008, 32'h0000_00A5);
        issue("miss", 1'b1, 32'hBFAE_0008, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b0);
        rd("unmapped", 16'h0020, 32'h0);
        wr("wr_sw_ro", 16'h0008, 4'b1111, 32'h0000_0011);
        rd("rd_sw2", 16'h0008, 32'h0000_00A5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
